uart_tx: RTL and testbench

- UART transmitter that consumes the divided baud square wave produced by the team's clock divider and serialises bytes onto a TX pin.
- Each rising edge of the baud wave marks one bit boundary.
- With the divider at N=624 on the 12 MHz iCESugar clock, bit boundaries are 1250 i_clk cycles apart (9600 baud).
- Upstream user logic hands bytes in over a valid/ready handshake; the block sits between the divider/user logic and the FPGA TX pad.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_strobe.sv | 25 ++
 rtl/uart_tx.sv | 146 ++++++++++++++
 tb/tb_uart_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and
// the parity helper used when a byte is accepted.
package uart_pkg;

  localparam int PARITY_NONE       = 0;
  localparam int PARITY_EVEN       = 1;
  localparam int PARITY_ODD        = 2;
  localparam int DEFAULT_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    PAR   = 3'd4,
    STOP  = 3'd5
  } tx_state_e;

  // Payload is zero-extended to 8 bits by the caller, so padding does not
  // disturb the XOR. Odd parity is the inverse of the even result.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic even_bit;
    even_bit = ^data;
    if (mode == PARITY_ODD) begin
      parity_bit = ~even_bit;
    end else begin
      parity_bit = even_bit;
    end
  endfunction

endpackage

// File: rtl/uart_baud_strobe.sv
// Turns the divided baud square wave into a one-cycle strobe on each rising
// edge. The input is already in the i_clk domain, so one register suffices.
module uart_baud_strobe
  import uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_baud,
  output logic o_tick
);

  logic baud_q;

  // Remember last cycle's baud level for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      baud_q <= 1'b0;
    end else begin
      baud_q <= i_baud;
    end
  end

  assign o_tick = i_baud & ~baud_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte over valid/ready, waits for the next baud
// tick and then shifts start, data (LSB first), optional parity and stop bits
// onto o_tx, one bit per baud period.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_baud,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int IDX_W = $clog2(DATA_BITS);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 stop_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 tick;
  logic                 accept;
  logic [7:0]           data_ext;
  logic                 par_d;

  uart_baud_strobe u_strobe (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_baud (i_baud),
    .o_tick (tick)
  );

  assign accept = i_valid & ready_q;

  // Zero-extend the payload and compute its parity at accept time.
  always_comb begin
    data_ext                = 8'h00;
    data_ext[DATA_BITS-1:0] = i_data;
    par_d                   = parity_bit(data_ext, PARITY);
  end

  // Frame sequencer; every output is registered and moves only on a tick
  // (or on accept / reset), so each bit lasts exactly one baud period.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A tick coinciding with accept is deliberately not used here.
          if (accept) begin
            shreg_q <= i_data;
            par_q   <= par_d;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ALIGN;
          end
        end
        ALIGN: begin
          if (tick) begin
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_q    <= shreg_q[0];
            idx_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (idx_q == IDX_W'(DATA_BITS - 1)) begin
              if (PARITY != PARITY_NONE) begin
                tx_q    <= par_q;
                state_q <= PAR;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              shreg_q <= {1'b0, shreg_q[DATA_BITS-1:1]};
              tx_q    <= shreg_q[1];
              idx_q   <= idx_q + IDX_W'(1);
            end
          end
        end
        PAR: begin
          if (tick) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_q == 1'(STOP_BITS - 1)) begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_tx    = tx_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. Four instances cover 8N1, 8E1, 8O1 and 8N2.
// The baud wave toggles every 4 clocks, so a tick happens in the cycle where
// bcnt % 8 == 4 and the resulting o_tx change is visible at bcnt % 8 == 5.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       baud;
  int         bcnt;
  logic       valid [4];
  logic [7:0] data  [4];
  logic       tx    [4];
  logic       ready [4];
  logic       busy  [4];
  logic       done  [4];
  int         tests;
  int         fails;

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_clk(clk), .i_rst(rst), .i_baud(baud), .i_data(data[0]), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]));
  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .i_clk(clk), .i_rst(rst), .i_baud(baud), .i_data(data[1]), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]));
  uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .i_clk(clk), .i_rst(rst), .i_baud(baud), .i_data(data[2]), .i_valid(valid[2]),
    .o_ready(ready[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]));
  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .i_clk(clk), .i_rst(rst), .i_baud(baud), .i_data(data[3]), .i_valid(valid[3]),
    .o_ready(ready[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_done(done[3]));

  // Free-running system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    bcnt = bcnt + 1;
    baud = ((bcnt % 8) >= 4) ? 1'b1 : 1'b0;
  endtask

  task automatic chk(input logic obs, input logic expv, input string tag);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk_int(input int obs, input int expv, input string tag);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 8; i++) begin
      if ((bcnt % 8) != ph) step();
    end
  endtask

  // Called right after the accepting edge. expv bit p is the line level of period p.
  task automatic check_frame(input int k, input logic [11:0] expv, input int nper,
                             input int n_align, input string tag);
    int cnt;
    cnt = 0;
    chk(tx[k], 1'b1, {tag, " accept tx"});
    chk(ready[k], 1'b0, {tag, " accept ready"});
    chk(busy[k], 1'b1, {tag, " accept busy"});
    chk(done[k], 1'b0, {tag, " accept done"});
    for (int i = 0; i < 16 && (bcnt % 8) != 4; i++) begin
      step();
      chk(tx[k], 1'b1, {tag, " align tx"});
      cnt++;
    end
    chk_int(cnt, n_align, {tag, " align length"});
    for (int p = 0; p < nper; p++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        chk(tx[k], expv[p], $sformatf("%s period%0d cyc%0d tx", tag, p, c));
        chk(done[k], 1'b0, $sformatf("%s period%0d cyc%0d done", tag, p, c));
      end
    end
    step();
    chk(done[k], 1'b1, {tag, " done pulse"});
    chk(ready[k], 1'b1, {tag, " ready after"});
    chk(busy[k], 1'b0, {tag, " busy after"});
    chk(tx[k], 1'b1, {tag, " idle tx"});
  endtask

  task automatic idle_after(input int k, input string tag);
    step();
    chk(done[k], 1'b0, {tag, " done one cycle"});
    chk(ready[k], 1'b1, {tag, " idle ready"});
  endtask

  task automatic accept_at0(input int k, input logic [7:0] d);
    wait_phase(0);
    valid[k] = 1'b1;
    data[k]  = d;
    step();
    valid[k] = 1'b0;
    data[k]  = 8'h00;
  endtask

  // Directed test sequence.
  initial begin
    tests = 0;
    fails = 0;
    bcnt  = 0;
    baud  = 1'b0;
    rst   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      valid[k] = 1'b1;
      data[k]  = 8'hFF;
    end

    // Reset held 3 cycles with valid asserted.
    repeat (3) begin
      step();
      for (int k = 0; k < 4; k++) begin
        chk(tx[k], 1'b1, $sformatf("rst tx%0d", k));
        chk(ready[k], 1'b1, $sformatf("rst ready%0d", k));
        chk(busy[k], 1'b0, $sformatf("rst busy%0d", k));
        chk(done[k], 1'b0, $sformatf("rst done%0d", k));
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) valid[k] = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      chk(busy[k], 1'b0, $sformatf("post-rst busy%0d", k));
      chk(ready[k], 1'b1, $sformatf("post-rst ready%0d", k));
    end

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1.
    accept_at0(0, 8'hA5);
    check_frame(0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 3, "8n1_a5");
    idle_after(0, "8n1_a5");

    // Parity: even 0x07 -> 1, odd 0x07 -> 0, even 0x00 -> 0.
    accept_at0(1, 8'h07);
    check_frame(1, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 3, "8e1_07");
    idle_after(1, "8e1_07");
    accept_at0(2, 8'h07);
    check_frame(2, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 3, "8o1_07");
    idle_after(2, "8o1_07");
    accept_at0(1, 8'h00);
    check_frame(1, {1'b0, 1'b1, 1'b0, 8'h00, 1'b0}, 11, 3, "8e1_00");
    idle_after(1, "8e1_00");

    // Two stop bits, valid held: 0xFF taken only in the cycle after o_done.
    wait_phase(0);
    valid[3] = 1'b1;
    data[3]  = 8'h00;
    step();
    data[3]  = 8'hFF;
    check_frame(3, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11, 3, "8n2_00");
    step();
    valid[3] = 1'b0;
    check_frame(3, {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11, 6, "8n2_ff");
    idle_after(3, "8n2_ff");

    // Accept in a tick cycle: line stays high a full period first.
    wait_phase(4);
    valid[0] = 1'b1;
    data[0]  = 8'h0F;
    step();
    valid[0] = 1'b0;
    check_frame(0, {2'b00, 1'b1, 8'h0F, 1'b0}, 10, 7, "tick_acc");
    idle_after(0, "tick_acc");

    // Reset in data bit 3 of 0xA5 (a 0 bit), then a clean frame.
    accept_at0(0, 8'hA5);
    repeat (38) step();
    chk(tx[0], 1'b0, "mid bit3 tx");
    chk(busy[0], 1'b1, "mid bit3 busy");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk(tx[0], 1'b1, "abort tx");
    chk(ready[0], 1'b1, "abort ready");
    chk(busy[0], 1'b0, "abort busy");
    chk(done[0], 1'b0, "abort done");
    for (int i = 0; i < 20; i++) begin
      step();
      chk(done[0], 1'b0, "abort no done");
      chk(tx[0], 1'b1, "abort idle tx");
    end
    accept_at0(0, 8'h3C);
    check_frame(0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 3, "post_rst_3c");
    idle_after(0, "post_rst_3c");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
